alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Execute-stage sequencer on the driving side of the ALU. It accepts decoded ops from
// the decode stage over a valid/ready handshake and registers operands/op onto
// srcAE/srcBE/ALUControlE. It holds them stable for the op's latency (Mul is a
// multicycle path), captures the ALU output, and presents the result to writeback
// over a second valid/ready handshake.
// PARAMETERS
// XLEN         32  datapath width
// MUL_LATENCY  4   cycles Mul operands are held before capture (legal range >=1)
// PORTS
// clk          in   1     clock, all state on rising edge
// reset        in   1     synchronous, active-high reset
// in_valid     in   1     decode presents an op
// in_ready     out  1     block can accept op this cycle
// in_op        in   3     000 Add, 001 Sub, 010 And, 011 Or, 100 Mul, 101-111 illegal
// in_a         in   XLEN  operand A
// in_b         in   XLEN  operand B
// in_rd        in   5     destination register tag, echoed to output
// srcAE        out  XLEN  registered operand A to ALU
// srcBE        out  XLEN  registered operand B to ALU
// ALUControlE  out  3     registered op code to ALU
// alu_out      in   XLEN  combinational ALU result
// out_valid    out  1     result available
// out_ready    in   1     writeback accepts result
// out_result   out  XLEN  captured result
// out_rd       out  5     tag of captured result
// out_illegal  out  1     captured op was 101-111
// busy         out  1     state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; srcAE=srcBE=0; ALUControlE=000; out_result=0; out_rd=0;
//   out_valid=0; out_illegal=0; mul counter=0. Reset mid-op abandons the op, with no out_valid.
// - States: IDLE, EXEC, WAIT_MUL, DONE. out_valid = (state==DONE).
// - in_ready = IDLE | (DONE & out_ready). Accept = in_valid & in_ready.
// - On accept: latch in_a/in_b/in_op into srcAE/srcBE/ALUControlE and latch in_rd.
//   If op==100, go to WAIT_MUL with cnt=MUL_LATENCY-1. Otherwise, go to EXEC.
// - EXEC: at the next edge, capture alu_out->out_result, rd->out_rd,
//   (op>=101)->out_illegal, and go to DONE.
// - WAIT_MUL: if cnt!=0, cnt--. If cnt==0, capture as in EXEC and go to DONE.
// - DONE: hold all outputs. On out_ready without accept, go to IDLE.
//   On out_ready with same-cycle accept, go directly to EXEC or WAIT_MUL.
// - Latency, from accept edge to out_valid high: 1 cycle for non-Mul ops,
//   MUL_LATENCY cycles for Mul. Max throughput is one op per 2 cycles.
// - srcAE/srcBE/ALUControlE change only on an accept edge or on reset. They stay
//   stable through WAIT_MUL and DONE.
// - Arithmetic is done entirely by the ALU and is mod 2^XLEN (Sub wraps; Mul keeps
//   the low XLEN bits). Illegal ops take the EXEC path; the ALU yields 0, so
//   out_result=0 and out_illegal=1.
// - in_valid while busy and not in the DONE&out_ready case: not accepted, and decode holds its inputs.
// TESTING
// 1 Add a=1 b=1 rd=3 -> out_valid 1 cycle after accept; out_result=2, out_rd=3, out_illegal=0.
// 2 Mul a=7 b=6 (MUL_LATENCY=4) -> in_ready=0 and srcAE=7 stable 4 cycles; then out_result=42.
// 3 Or 0x40000001|0x1, out_ready=0 for 3 cycles -> out_result=0x40000001 held, in_ready=0;
//   then out_ready=1 with in_valid Sub 5-7 same cycle -> accepted; next result 0xFFFFFFFE.
// 4 And 0xF0F0F0F0&0xFF00FF00 back-to-back with Add 0xFFFFFFFF+1 -> 0xF000F000 then 0x00000000.
// 5 in_op=111 a=9 b=9 -> out_result=0, out_illegal=1 after 1 cycle.
// 6 reset pulse during WAIT_MUL -> out_valid never rises; next cycle state IDLE, in_ready=1,
//   ALUControlE=000, srcAE=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Execute-stage sequencer that registers ALU operands, holds
//               them for the op latency and hands the result to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] srcAE,
    output logic [XLEN-1:0] srcBE,
    output logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] alu_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic            busy
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_exec     = 2'd1;
    localparam logic [1:0] c_st_wait_mul = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    localparam logic [2:0]       c_op_mul      = 3'b100;
    localparam logic [2:0]       c_op_first_il = 3'b101;
    localparam logic [CNT_W-1:0] c_cnt_init    = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       r_rd;
    logic             w_accept;
    logic             w_capture;

    // A new op may enter in the same cycle the previous result retires.
    assign in_ready  = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_idle;
            end
            c_st_exec: begin
                w_capture   = 1'b1;
                w_state_nxt = c_st_done;
            end
            c_st_wait_mul: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        // Accept overrides the retire-to-idle path out of DONE.
        if (w_accept) begin
            if (in_op == c_op_mul) begin
                w_state_nxt = c_st_wait_mul;
                w_cnt_nxt   = c_cnt_init;
            end else begin
                w_state_nxt = c_st_exec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_rd        <= '0;
            srcAE       <= '0;
            srcBE       <= '0;
            ALUControlE <= 3'b000;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                srcAE       <= in_a;
                srcBE       <= in_b;
                ALUControlE <= in_op;
                r_rd        <= in_rd;
            end
            if (w_capture) begin
                out_result  <= alu_out;
                out_rd      <= r_rd;
                out_illegal <= (ALUControlE >= c_op_first_il);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Randomized self-checking bench for alu_issue_ctrl against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 4;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] srcAE;
    logic [XLEN-1:0] srcBE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] alu_out;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            busy;

    int n_chk;
    int n_pass;

    // Reference model: one outstanding op and the cycles until its result shows.
    bit          m_has;
    int          m_left;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    bit          m_ill;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;
    bit          m_hold;

    alu_issue_ctrl #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .srcAE       (srcAE),
        .srcBE       (srcBE),
        .ALUControlE (ALUControlE),
        .alu_out     (alu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_f(ALUControlE, srcAE, srcBE);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic ordy,
                        input logic rst);
        bit exp_valid;
        bit exp_ready;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        out_ready = ordy;
        #1;
        exp_valid = m_has && (m_left == 0);
        exp_ready = !m_has || (exp_valid && ordy);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_has));
        check("srcAE", srcAE, m_a);
        check("srcBE", srcBE, m_b);
        check("ALUControlE", 32'(ALUControlE), 32'(m_op));
        if (exp_valid) begin
            check("out_result", out_result, m_res);
            check("out_rd", 32'(out_rd), 32'(m_rd));
            check("out_illegal", 32'(out_illegal), 32'(m_ill));
        end
        if (rst) begin
            m_has  = 0;
            m_left = 0;
            m_a    = '0;
            m_b    = '0;
            m_op   = '0;
            m_hold = 0;
        end else begin
            if (m_has) begin
                if (exp_valid && ordy) m_has = 0;
                else if (m_left > 0)   m_left--;
            end
            if (v && exp_ready) begin
                m_has  = 1;
                m_left = (op == 3'd4) ? MUL_LATENCY : 1;
                m_res  = alu_f(op, a, b);
                m_rd   = rd;
                m_ill  = (op > 3'd4);
                m_a    = a;
                m_b    = b;
                m_op   = op;
            end
            m_hold = v && !exp_ready;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic        r_v;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        m_has     = 0;
        m_left    = 0;
        m_a       = '0;
        m_b       = '0;
        m_op      = '0;
        m_res     = '0;
        m_rd      = '0;
        m_ill     = 0;
        m_hold    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Add 1+1, result one cycle after accept.
        step(1, 3'd0, 32'd1, 32'd1, 5'd3, 1, 0);
        step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);
        step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // Mul 7*6 holding operands for the full latency.
        step(1, 3'd4, 32'd7, 32'd6, 5'd9, 1, 0);
        repeat (MUL_LATENCY + 2) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // Or with writeback stalled, then Sub accepted on the retire cycle.
        step(1, 3'd3, 32'h4000_0001, 32'h1, 5'd4, 0, 0);
        repeat (4) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0);
        step(1, 3'd1, 32'd5, 32'd7, 5'd5, 1, 0);
        repeat (3) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // And followed immediately by Add held until accepted.
        step(1, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1, 0);
        repeat (3) step(1, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd7, 1, 0);
        step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // Illegal opcode.
        step(1, 3'd7, 32'd9, 32'd9, 5'd8, 1, 0);
        repeat (2) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // Reset in the middle of a Mul.
        step(1, 3'd4, 32'd3, 32'd5, 5'd10, 1, 0);
        repeat (2) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);
        step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 1);
        repeat (MUL_LATENCY + 2) step(0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0);

        // Randomized traffic; stalled requests keep their payload.
        r_v  = 0;
        r_op = '0;
        r_a  = '0;
        r_b  = '0;
        r_rd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_hold) begin
                r_v  = ($urandom_range(0, 99) < 60);
                r_op = 3'($urandom_range(0, 9));
                if ($urandom_range(0, 9) > 7) r_op = 3'd4;
                r_a  = rand_operand();
                r_b  = rand_operand();
                r_rd = 5'($urandom_range(0, 31));
            end
            step(r_v, r_op, r_a, r_b, r_rd, ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
